// File: rtl/pucch_scrambler_qm.sv
// rtl/pucch_scrambler_qm.sv - PUCCH/UCI Gold-sequence bit scrambler with run-time Qm symbol packer
module pucch_scrambler_qm #(
   parameter int SEQ_W  = 8,
   parameter int MAX_QM = 2,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_len,
   input  logic [3:0]        i_qm,
   input  logic              i_bit,
`ifdef PUCCH_SCRAMBLER_PLACEHOLDER_EN
   input  logic [1:0]        i_bit_tag,
`endif
   input  logic              i_bit_valid,
   output logic              o_bit_ready,
   output logic              o_seq_start,
   output logic              o_seq_get,
   input  logic [SEQ_W-1:0]  i_seq_word,
   input  logic              i_seq_valid,
   output logic              o_bit,
   output logic              o_bit_valid,
   output logic [MAX_QM-1:0] o_sym,
   output logic              o_sym_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam int PTR_W = $clog2(SEQ_W);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  acc_cnt;
   logic [3:0]        qm_q;
   logic [3:0]        qm_in;
   logic [LEN_W:0]    words_total;
   logic [LEN_W:0]    words_req;
   logic [SEQ_W-1:0]  seq_buf [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        filled;
   logic [1:0]        outstanding;
   logic [PTR_W-1:0]  bit_ptr;
   logic [3:0]        sym_cnt;
   logic [MAX_QM-1:0] sym_acc;
   logic [MAX_QM-1:0] sym_nxt;
   logic              seq_bit;
   logic              out_bit;
   logic              sym_last;
   logic              accept;
   logic              push;
   logic              pop;
   logic              get_req;

   assign o_busy      = (state != S_IDLE);
   assign o_done      = (state == S_DONE);
   assign o_bit_ready = (state == S_RUN) && (filled != 2'd0) && (acc_cnt < len_q);
   assign accept      = i_bit_valid && o_bit_ready;
   assign seq_bit     = seq_buf[rd_ptr][bit_ptr];
   assign push        = i_seq_valid && (state == S_RUN) && !i_start && (outstanding != 2'd0);
   assign pop         = accept && (bit_ptr == PTR_W'(SEQ_W - 1));
   assign get_req     = (state == S_RUN) && !i_start
                        && (({1'b0, filled} + {1'b0, outstanding}) < 3'd2)
                        && (words_req < words_total);
   assign sym_last    = ((sym_cnt + 4'd1) == qm_q) || ((acc_cnt + LEN_W'(1)) == len_q);

   // Clamp the requested modulation order into 1..MAX_QM
   always_comb begin
      qm_in = i_qm;
      if (i_qm == 4'd0 || i_qm > 4'(MAX_QM)) qm_in = 4'(MAX_QM);
   end

   // Output bit: scrambled data, or an x/y-tagged value that bypasses the XOR
   always_comb begin
      out_bit = i_bit ^ seq_bit;
`ifdef PUCCH_SCRAMBLER_PLACEHOLDER_EN
      if (i_bit_tag == 2'b01)      out_bit = 1'b1;
      else if (i_bit_tag == 2'b10) out_bit = o_bit;
`endif
   end

   // Insert the current output bit at the packer's fill position
   always_comb begin
      sym_nxt = sym_acc;
      for (int k = 0; k < MAX_QM; k++) begin
         if (sym_cnt == 4'(k)) sym_nxt[k] = out_bit;
      end
   end

   // Run control: IDLE -> RUN on start, RUN -> DONE once all E bits are in, DONE for one cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         o_seq_start <= 1'b0;
         len_q       <= '0;
         qm_q        <= 4'd1;
         words_total <= '0;
      end else if (i_start) begin
         state       <= S_RUN;
         o_seq_start <= 1'b1;
         len_q       <= i_len;
         qm_q        <= qm_in;
         words_total <= ({1'b0, i_len} + (LEN_W+1)'(SEQ_W - 1)) >> PTR_W;
      end else begin
         o_seq_start <= 1'b0;
         case (state)
            S_RUN:   if (acc_cnt == len_q) state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Two-entry sequence buffer with request/outstanding accounting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) seq_buf[k] <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         filled      <= 2'd0;
         outstanding <= 2'd0;
         words_req   <= '0;
         o_seq_get   <= 1'b0;
      end else if (i_start) begin
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         filled      <= 2'd0;
         outstanding <= 2'd0;
         words_req   <= '0;
         o_seq_get   <= 1'b0;
      end else begin
         o_seq_get <= get_req;
         if (get_req) words_req <= words_req + (LEN_W+1)'(1);
         if (push) begin
            seq_buf[wr_ptr] <= i_seq_word;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   filled <= filled + 2'd1;
            2'b01:   filled <= filled - 2'd1;
            default: filled <= filled;
         endcase
         case ({get_req, push})
            2'b10:   outstanding <= outstanding + 2'd1;
            2'b01:   outstanding <= outstanding - 2'd1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Bit datapath: scramble, count accepted bits, pack symbols with zero-padded final flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_cnt     <= '0;
         bit_ptr     <= '0;
         sym_cnt     <= 4'd0;
         sym_acc     <= '0;
         o_bit       <= 1'b0;
         o_bit_valid <= 1'b0;
         o_sym       <= '0;
         o_sym_valid <= 1'b0;
      end else if (i_start) begin
         acc_cnt     <= '0;
         bit_ptr     <= '0;
         sym_cnt     <= 4'd0;
         sym_acc     <= '0;
         o_bit       <= 1'b0;
         o_bit_valid <= 1'b0;
         o_sym_valid <= 1'b0;
      end else begin
         o_bit_valid <= accept;
         o_sym_valid <= accept && sym_last;
         if (accept) begin
            o_bit   <= out_bit;
            acc_cnt <= acc_cnt + LEN_W'(1);
            bit_ptr <= bit_ptr + PTR_W'(1);
            if (sym_last) begin
               o_sym   <= sym_nxt;
               sym_acc <= '0;
               sym_cnt <= 4'd0;
            end else begin
               sym_acc <= sym_nxt;
               sym_cnt <= sym_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pucch_scrambler_qm.sv
// tb/tb_pucch_scrambler_qm.sv - scoreboard testbench for pucch_scrambler_qm
`timescale 1ns/1ps
module tb_pucch_scrambler_qm;

   localparam int SEQ_W  = 8;
   localparam int MAX_QM = 2;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              i_start = 1'b0;
   logic [LEN_W-1:0]  i_len = '0;
   logic [3:0]        i_qm = 4'd0;
   logic              i_bit = 1'b0;
   logic [1:0]        i_bit_tag = 2'b00;
   logic              i_bit_valid = 1'b0;
   logic              o_bit_ready;
   logic              o_seq_start;
   logic              o_seq_get;
   logic [SEQ_W-1:0]  i_seq_word = '0;
   logic              i_seq_valid = 1'b0;
   logic              o_bit;
   logic              o_bit_valid;
   logic [MAX_QM-1:0] o_sym;
   logic              o_sym_valid;
   logic              o_busy;
   logic              o_done;

   always #5 clk = ~clk;

   pucch_scrambler_qm #(.SEQ_W(SEQ_W), .MAX_QM(MAX_QM), .LEN_W(LEN_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_len       (i_len),
      .i_qm        (i_qm),
      .i_bit       (i_bit),
`ifdef PUCCH_SCRAMBLER_PLACEHOLDER_EN
      .i_bit_tag   (i_bit_tag),
`endif
      .i_bit_valid (i_bit_valid),
      .o_bit_ready (o_bit_ready),
      .o_seq_start (o_seq_start),
      .o_seq_get   (o_seq_get),
      .i_seq_word  (i_seq_word),
      .i_seq_valid (i_seq_valid),
      .o_bit       (o_bit),
      .o_bit_valid (o_bit_valid),
      .o_sym       (o_sym),
      .o_sym_valid (o_sym_valid),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0]        words [$];
   logic              bitv [$];
   logic [1:0]        tagv [$];
   logic              exp_bit_q [$];
   logic [MAX_QM-1:0] exp_sym_q [$];
   int                pend [$];
   int                c_lat = 1;
   int                cg_cyc = 0;
   int                widx = 0;

   int                mon_cyc = 0;
   int                gets, dones, bitvalids, symvalids, stalls, last_bv, obs_n;
   logic [63:0]       obs_word;
   logic [MAX_QM-1:0] first_sym, last_sym;
   bit                chk_get_next = 0;

   // c_gen model: answers each request after c_lat cycles; restarts on o_seq_start
   always @(negedge clk) begin
      cg_cyc++;
      if (o_seq_start) begin
         pend.delete();
         widx = 0;
      end
      if (o_seq_get) pend.push_back(cg_cyc + c_lat);
      i_seq_valid = 1'b0;
      if (pend.size() > 0 && pend[0] <= cg_cyc) begin
         void'(pend.pop_front());
         i_seq_word  = (widx < words.size()) ? words[widx] : 8'h00;
         widx++;
         i_seq_valid = 1'b1;
      end
   end

   // Output monitor: scoreboard compare and per-run statistics
   always @(negedge clk) begin
      mon_cyc++;
      if (chk_get_next) begin
         check("get_after_seq_start", o_seq_get, 1);
         chk_get_next = 0;
      end
      if (o_seq_start) chk_get_next = 1;
      if (o_seq_get) gets++;
      if (o_bit_valid) begin
         bitvalids++;
         last_bv = mon_cyc;
         if (obs_n < 64) obs_word[obs_n] = o_bit;
         obs_n++;
         if (exp_bit_q.size() == 0) check("bit_unexpected", 1, 0);
         else check("bit", o_bit, exp_bit_q.pop_front());
      end
      if (o_sym_valid) begin
         if (symvalids == 0) first_sym = o_sym;
         last_sym = o_sym;
         symvalids++;
         check("sym_with_bit_valid", o_bit_valid, 1);
         if (exp_sym_q.size() == 0) check("sym_unexpected", 1, 0);
         else check("sym", o_sym, exp_sym_q.pop_front());
      end
      if (o_done) begin
         dones++;
         check("done_after_last_bit", mon_cyc, last_bv + 1);
         check("busy_at_done", o_busy, 1);
      end
   end

   task automatic set_bits(input int len, input int mode);
      bitv.delete();
      tagv.delete();
      for (int k = 0; k < len; k++) begin
         bitv.push_back(mode == 2 ? 1'($urandom) : 1'(mode));
         tagv.push_back(2'b00);
      end
   endtask

   task automatic set_words(input int n);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back(8'($urandom));
   endtask

   // Drive one run from a negedge; stops early (abort) when stop < len
   task automatic run(input int len, input logic [3:0] qm, input int lat, input int stop);
      int k, sc, budget, qm_eff;
      logic c, ob, prev;
      logic [MAX_QM-1:0] sa;
      qm_eff = (qm == 0 || qm > MAX_QM) ? MAX_QM : int'(qm);
      #1;
      c_lat = lat;
      gets = 0; dones = 0; bitvalids = 0; symvalids = 0; stalls = 0; obs_n = 0; obs_word = '0;
      i_start = 1'b1; i_len = LEN_W'(len); i_qm = qm;
      @(negedge clk);
      i_start = 1'b0;
      k = 0; sc = 0; sa = '0; prev = 1'b0; budget = 0;
      while (k < stop && budget < 2000) begin
         i_bit = bitv[k]; i_bit_tag = tagv[k]; i_bit_valid = 1'b1;
         #1;
         if (o_bit_ready) begin
            c  = words[k / SEQ_W][k % SEQ_W];
            ob = bitv[k] ^ c;
`ifdef PUCCH_SCRAMBLER_PLACEHOLDER_EN
            if (tagv[k] == 2'b01) ob = 1'b1;
            else if (tagv[k] == 2'b10) ob = prev;
`endif
            prev = ob;
            exp_bit_q.push_back(ob);
            sa = sa | (MAX_QM'(ob) << sc);
            sc++;
            if (sc == qm_eff || k == len - 1) begin
               exp_sym_q.push_back(sa);
               sa = '0;
               sc = 0;
            end
            k++;
         end else if (k > 0) begin
            stalls++;
         end
         @(negedge clk);
         budget++;
      end
      i_bit_valid = 1'b0;
      check("bit_budget", k, stop);
      if (stop < len) begin
         check("abort_no_done", dones, 0);
      end else begin
         budget = 0;
         while (dones == 0 && budget < 200) begin
            @(negedge clk);
            budget++;
         end
         repeat (3) @(negedge clk);
         check("done_once", dones, 1);
         check("bits_out", bitvalids, len);
         check("gets", gets, (len + SEQ_W - 1) / SEQ_W);
         check("busy_after_done", o_busy, 0);
         check("scoreboard_empty", exp_bit_q.size() + exp_sym_q.size(), 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", {o_bit_ready, o_seq_start, o_seq_get, o_bit, o_bit_valid,
                              o_sym, o_sym_valid, o_busy, o_done}, 0);
      rst = 1'b1;
      @(negedge clk);

      // E=16, Qm=2, zero bits, words A5/3C
      words = '{8'hA5, 8'h3C};
      set_bits(16, 0);
      run(16, 4'd2, 2, 16);
      check("t1_pattern", obs_word[15:0], 16'h3CA5);
      check("t1_syms", symvalids, 8);
      check("t1_first_sym", first_sym, 2'b01);

      // Qm=1, E=5, ones, word FF
      words = '{8'hFF};
      set_bits(5, 1);
      run(5, 4'd1, 3, 5);
      check("t2_pattern", obs_word[4:0], 5'b00000);
      check("t2_syms", symvalids, 5);
      check("t2_gets", gets, 1);

      // Qm=2, E=3, partial final symbol
      words = '{8'h07};
      set_bits(3, 0);
      run(3, 4'd2, 1, 3);
      check("t3_syms", symvalids, 2);
      check("t3_first_sym", first_sym, 2'b11);
      check("t3_last_sym", last_sym, 2'b01);

      // Slow c_gen forces the buffer to drain
      set_words(3);
      set_bits(24, 2);
      run(24, 4'd2, 20, 24);
      check("t4_stalled", stalls > 0, 1);

      // Out-of-range Qm clamps to MAX_QM
      set_words(1);
      set_bits(5, 2);
      run(5, 4'd0, 2, 5);
      check("t5_qm0_syms", symvalids, 3);
      set_words(1);
      set_bits(4, 2);
      run(4, 4'd9, 2, 4);
      check("t5_qm9_syms", symvalids, 2);

      // Abort at bit 7 of a 24-bit run, then E=8
      set_words(3);
      set_bits(24, 2);
      run(24, 4'd2, 2, 7);
      set_words(1);
      set_bits(8, 2);
      run(8, 4'd1, 2, 8);
      check("t6_syms", symvalids, 8);

      // Asynchronous reset mid-run; late words must be discarded
      set_words(2);
      set_bits(16, 2);
      run(16, 4'd2, 10, 5);
      #2;
      rst = 1'b0;
      #1;
      check("t7_reset_outputs", {o_bit_ready, o_seq_start, o_seq_get, o_bit, o_bit_valid,
                                 o_sym, o_sym_valid, o_busy, o_done}, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      check("t7_idle_after_reset", {o_busy, o_bit_ready, o_bit_valid}, 0);
      exp_bit_q.delete();
      exp_sym_q.delete();
      set_words(2);
      set_bits(12, 2);
      run(12, 4'd2, 4, 12);

      // Random runs
      for (int r = 0; r < 6; r++) begin
         int len;
         len = 1 + int'($urandom_range(0, 39));
         set_words((len + SEQ_W - 1) / SEQ_W);
         set_bits(len, 2);
         run(len, 4'($urandom_range(1, 3)), 1 + int'($urandom_range(0, 7)), len);
      end

`ifdef PUCCH_SCRAMBLER_PLACEHOLDER_EN
      // Placeholders: data, x, y, data with c = 1,0,0,1
      words = '{8'h09};
      set_bits(4, 0);
      bitv[3] = 1'b1;
      tagv[1] = 2'b01;
      tagv[2] = 2'b10;
      run(4, 4'd2, 2, 4);
      check("t8_pattern", obs_word[3:0], 4'b0111);
      check("t8_first_sym", first_sym, 2'b11);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
